alu_multicycle: RTL

Parametrised, clocked successor to the datapath's combinational ALU. It keeps the 6-bit operation encoding and the 2-bit ALUOp branch/immediate modes, and adds:
- a start/busy/done handshake;
- registered outputs;
- iterative multiply, divide and modulo in place of single-cycle `*`, `/` and `%`.

It sits in the execute stage. The control unit stalls the pipeline while `busy` is high.

---
 rtl/alu_pkg.sv | 33 +++
 rtl/alu_iter_unit.sv | 61 ++++++
 rtl/alu_multicycle.sv | 133 +++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: shared op codes, ALUOp modes and FSM states
// for the multicycle execute-stage ALU.
package alu_pkg;

    localparam logic [5:0] OP_LD  = 6'd0;
    localparam logic [5:0] OP_ADD = 6'd1;
    localparam logic [5:0] OP_SUB = 6'd2;
    localparam logic [5:0] OP_AND = 6'd3;
    localparam logic [5:0] OP_OR  = 6'd4;
    localparam logic [5:0] OP_XOR = 6'd5;
    localparam logic [5:0] OP_NOT = 6'd6;
    localparam logic [5:0] OP_SHL = 6'd7;
    localparam logic [5:0] OP_SHR = 6'd8;
    localparam logic [5:0] OP_MUL = 6'd9;
    localparam logic [5:0] OP_DIV = 6'd10;
    localparam logic [5:0] OP_MOD = 6'd11;

    localparam logic [1:0] ALUOP_NORM = 2'b00;
    localparam logic [1:0] ALUOP_BNE  = 2'b10;
    localparam logic [1:0] ALUOP_LDI  = 2'b01;
    localparam logic [1:0] ALUOP_ADDR = 2'b11;

    typedef enum logic [1:0] {
        IDLE,
        ITER,
        FIN
    } state_t;

    function automatic logic is_iter_op(input logic [5:0] op);
        return (op == OP_MUL) || (op == OP_DIV) || (op == OP_MOD);
    endfunction

endpackage

// File: rtl/alu_iter_unit.sv
// alu_iter_unit: shared MSB-first shift-add multiplier and
// restoring divider, one step per cycle.
module alu_iter_unit
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    localparam int CW = $clog2(WIDTH)
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             load,
    input  logic             step,
    input  logic [5:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             last,
    output logic [WIDTH-1:0] acc,
    output logic [WIDTH-1:0] shreg
);

    logic [WIDTH-1:0] opnd;
    logic [CW-1:0]    count;
    logic             is_div;
    logic [WIDTH:0]   part;
    logic [WIDTH:0]   trial;

    // A zero divisor never borrows, so the quotient fills with ones
    // and the dividend shifts whole into the remainder.
    assign part  = {acc, shreg[WIDTH-1]};
    assign trial = part - {1'b0, opnd};
    assign last  = (count == '0);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            opnd   <= '0;
            count  <= '0;
            is_div <= 1'b0;
            acc    <= '0;
            shreg  <= '0;
        end else if (load) begin
            is_div <= (op != OP_MUL);
            opnd   <= (op != OP_MUL) ? b : a;
            shreg  <= (op != OP_MUL) ? a : b;
            acc    <= '0;
            count  <= CW'(WIDTH - 1);
        end else if (step) begin
            if (count != '0)
                count <= count - CW'(1);
            if (is_div) begin
                shreg <= {shreg[WIDTH-2:0], ~trial[WIDTH]};
                acc   <= trial[WIDTH] ? part[WIDTH-1:0]
                                      : trial[WIDTH-1:0];
            end else begin
                shreg <= {shreg[WIDTH-2:0], 1'b0};
                acc   <= {acc[WIDTH-2:0], 1'b0}
                       + (shreg[WIDTH-1] ? opnd : '0);
            end
        end
    end

endmodule

// File: rtl/alu_multicycle.sv
// alu_multicycle: execute-stage ALU with start/busy/done handshake,
// registered outputs and iterative mul/div/mod.
module alu_multicycle
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start,
    input  logic [WIDTH-1:0] data1,
    input  logic [WIDTH-1:0] data2,
    input  logic [5:0]       operation,
    input  logic [1:0]       ALUOp,
    output logic             busy,
    output logic             done,
    output logic             zero,
    output logic [WIDTH-1:0] aluResult,
    output logic             divByZero,
    output logic             illegalOp
);

    state_t           state;
    logic             zero_q;
    logic             div_q;
    logic             dz_q;
    logic [WIDTH-1:0] single_res;
    logic             single_ill;
    logic             shift_big;
    logic             cmp;
    logic             multi;
    logic             load;
    logic             step;
    logic             last;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] shreg;

    assign shift_big = |data2[WIDTH-1:SHW];
    assign cmp = (ALUOp == ALUOP_NORM) ? (data1 == data2)
               : (ALUOp == ALUOP_BNE)  ? (data1 != data2)
               : 1'b0;
    assign multi = !ALUOp[0] && is_iter_op(operation);
    assign load  = (state == IDLE) && start && multi;
    assign step  = (state == ITER);

    always_comb begin
        single_res = '0;
        single_ill = 1'b0;
        if (ALUOp[0]) begin
            single_res = data2;
        end else begin
            case (operation)
                OP_LD:  single_res = data1;
                OP_ADD: single_res = data1 + data2;
                OP_SUB: single_res = data1 - data2;
                OP_AND: single_res = data1 & data2;
                OP_OR:  single_res = data1 | data2;
                OP_XOR: single_res = data1 ^ data2;
                OP_NOT: single_res = ~data1;
                OP_SHL: single_res = shift_big ? '0
                                   : data1 << data2[SHW-1:0];
                OP_SHR: single_res = shift_big ? '0
                                   : data1 >> data2[SHW-1:0];
                OP_MUL, OP_DIV, OP_MOD: single_res = '0;
                default: single_ill = 1'b1;
            endcase
        end
    end

    alu_iter_unit #(.WIDTH(WIDTH)) u_iter (
        .clock   (clock),
        .reset_n (reset_n),
        .load    (load),
        .step    (step),
        .op      (operation),
        .a       (data1),
        .b       (data2),
        .last    (last),
        .acc     (acc),
        .shreg   (shreg)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            zero      <= 1'b0;
            divByZero <= 1'b0;
            illegalOp <= 1'b0;
            aluResult <= '0;
            zero_q    <= 1'b0;
            div_q     <= 1'b0;
            dz_q      <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start && multi) begin
                        state  <= ITER;
                        busy   <= 1'b1;
                        zero_q <= cmp;
                        div_q  <= (operation == OP_DIV);
                        dz_q   <= (operation != OP_MUL)
                               && (data2 == '0);
                    end else if (start) begin
                        aluResult <= single_res;
                        zero      <= cmp;
                        illegalOp <= single_ill;
                        divByZero <= 1'b0;
                        done      <= 1'b1;
                    end
                end
                ITER: begin
                    if (last)
                        state <= FIN;
                end
                FIN: begin
                    aluResult <= div_q ? shreg : acc;
                    zero      <= zero_q;
                    divByZero <= dz_q;
                    illegalOp <= 1'b0;
                    done      <= 1'b1;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
